// File: rtl/seq_barrel_shifter_if.sv
// Handshake and data bundle between a multicycle controller and the shifter.
interface seq_barrel_shifter_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               start;
  logic [WIDTH-1:0]   operand;
  logic [SHAMT_W-1:0] shamt;
  logic [1:0]         mode;
  logic               ready;
  logic [WIDTH-1:0]   result;
  logic               result_valid;

  // Controller side: issues requests, consumes the held result.
  modport master (
    output start, operand, shamt, mode,
    input  ready, result, result_valid
  );

  // Shifter side.
  modport slave (
    input  start, operand, shamt, mode,
    output ready, result, result_valid
  );
endinterface

// File: rtl/seq_barrel_shifter.sv
// Multicycle shifter/rotator: one log2 stage per clock, largest stage first.
// Modes: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
module seq_barrel_shifter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHAMT_W    = 5,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input logic                  clock,
  input logic                  reset,
  seq_barrel_shifter_if.slave  bus
);

  localparam int unsigned CNT_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [1:0]         mode_q, mode_d;

  logic [SHAMT_W:0]   stage_amt;
  logic [SHAMT_W:0]   rol_amt;
  logic [SHAMT_W-1:0] low_mask;
  logic               low_zero;
  logic [WIDTH-1:0]   staged;

  // Shift applied by the current stage, and whether any lower stage remains to do work.
  always_comb begin
    stage_amt = (SHAMT_W + 1)'(1) << cnt_q;
    rol_amt   = (SHAMT_W + 1)'(WIDTH) - stage_amt;
    low_mask  = stage_amt[SHAMT_W-1:0] - SHAMT_W'(1);
    low_zero  = (shamt_q & low_mask) == '0;
    staged    = result_q;
    unique case (mode_q)
      2'b00:   staged = result_q << stage_amt;
      2'b01:   staged = result_q >> stage_amt;
      // Sign bit of the working value is the original sign at every stage.
      2'b10:   staged = WIDTH'($signed(result_q) >>> stage_amt);
      2'b11:   staged = (result_q << stage_amt) | (result_q >> rol_amt);
      default: staged = result_q;
    endcase
  end

  // Next-state logic: accept in IDLE/DONE, walk stages down to bit 0 in BUSY.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    shamt_d  = shamt_q;
    mode_d   = mode_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          result_d = bus.operand;
          shamt_d  = bus.shamt;
          mode_d   = bus.mode;
          cnt_d    = CNT_W'(SHAMT_W - 1);
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (shamt_q[cnt_q]) begin
          result_d = staged;
        end
        if (cnt_q == '0 || (EARLY_EXIT && low_zero)) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      result_q <= '0;
      cnt_q    <= '0;
      shamt_q  <= '0;
      mode_q   <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      shamt_q  <= shamt_d;
      mode_q   <= mode_d;
    end
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    bus.ready        = (state_q == StIdle) || (state_q == StDone);
    bus.result_valid = (state_q == StDone);
    bus.result       = result_q;
  end

endmodule
